// File: rtl/trigger_sequencer.sv
// trigger_sequencer: multi-channel pulse train generator started by a master trigger edge.
// Each enabled channel snapshots its delay/length/period/count at the accepted edge and then
// runs its own train, so register writes never disturb a train already in flight.
// Ports:
//   ipClk, ipReset          clock, async active-high reset
//   ipEnable[N]             per-channel enable
//   ipDelay/ipLength/ipPeriod [N*W]  per-channel timing, cycles
//   ipCount[N*CW]           pulses per train, 0 = continuous
//   ipMasterTrigger         level input, rising edge starts sequences
//   opTrigger/opBusy/opOverrun [N]   registered per-channel outputs

module trigger_sequencer_ch #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic          ipClk,
  input  logic          ipReset,
  input  logic          ipEnable,
  input  logic [W-1:0]  ipDelay,
  input  logic [W-1:0]  ipLength,
  input  logic [W-1:0]  ipPeriod,
  input  logic [CW-1:0] ipCount,
  input  logic          ipAccept,
  output logic          opTrigger,
  output logic          opBusy,
  output logic          opOverrun
);
  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  state_t        state;
  logic [W-1:0]  cnt;      // cycles left in the current state
  logic [W-1:0]  hiLen;    // max(L,1): HIGH always occupies at least one cycle
  logic [W-1:0]  lowLen;   // Peff - hiLen, may be 0 only when L=0
  logic [CW-1:0] cSnap;
  logic [CW-1:0] pcnt;     // pulses started, saturating
  logic          pulseOn;  // L != 0

  logic [W-1:0]  inHi, inLow;
  logic [CW-1:0] pcntInc;
  logic          lastPulse, finishing, startNow;

  // Peff = max(P, L+1); low time is rise-to-rise spacing minus the HIGH time.
  assign inHi    = (ipLength == '0) ? W'(1) : ipLength;
  assign inLow   = (ipPeriod > ipLength) ? (ipPeriod - inHi) :
                   ((ipLength == '0) ? '0 : W'(1));
  assign pcntInc = (pcnt == '1) ? pcnt : pcnt + CW'(1);

  assign lastPulse = (cSnap != '0) && (pcnt == cSnap);
  // Final HIGH cycle of a finite train: a new edge here is a clean back-to-back start.
  assign finishing = (state == HIGH) && (cnt <= W'(1)) && lastPulse;
  assign startNow  = ipAccept && ipEnable && ((state == IDLE) || finishing);

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state     <= IDLE;
      cnt       <= '0;
      hiLen     <= '0;
      lowLen    <= '0;
      cSnap     <= '0;
      pcnt      <= '0;
      pulseOn   <= 1'b0;
      opTrigger <= 1'b0;
      opBusy    <= 1'b0;
      opOverrun <= 1'b0;
    end else begin
      opOverrun <= ipAccept && ipEnable && (state != IDLE) && !finishing;
      if (startNow) begin
        hiLen   <= inHi;
        lowLen  <= inLow;
        cSnap   <= ipCount;
        pulseOn <= (ipLength != '0);
        opBusy  <= 1'b1;
        if (ipDelay == '0) begin
          state     <= HIGH;
          cnt       <= inHi;
          pcnt      <= CW'(1);
          opTrigger <= (ipLength != '0);
        end else begin
          state     <= DELAY;
          cnt       <= ipDelay;
          pcnt      <= '0;
          opTrigger <= 1'b0;
        end
      end else if ((state != IDLE) && !ipEnable) begin
        state     <= IDLE;
        opTrigger <= 1'b0;
        opBusy    <= 1'b0;
      end else begin
        case (state)
          DELAY, LOW: begin
            if (cnt <= W'(1)) begin
              state     <= HIGH;
              cnt       <= hiLen;
              pcnt      <= pcntInc;
              opTrigger <= pulseOn;
            end else begin
              cnt <= cnt - W'(1);
            end
          end
          HIGH: begin
            if (cnt <= W'(1)) begin
              if (lastPulse) begin
                state     <= IDLE;
                opTrigger <= 1'b0;
                opBusy    <= 1'b0;
              end else if (lowLen == '0) begin
                // L=0 with Peff=1: invisible pulse every cycle
                cnt  <= hiLen;
                pcnt <= pcntInc;
              end else begin
                state     <= LOW;
                cnt       <= lowLen;
                opTrigger <= 1'b0;
              end
            end else begin
              cnt <= cnt - W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

module trigger_sequencer #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic            ipClk,
  input  logic            ipReset,
  input  logic [N-1:0]    ipEnable,
  input  logic [N*W-1:0]  ipDelay,
  input  logic [N*W-1:0]  ipLength,
  input  logic [N*W-1:0]  ipPeriod,
  input  logic [N*CW-1:0] ipCount,
  input  logic            ipMasterTrigger,
  output logic [N-1:0]    opTrigger,
  output logic [N-1:0]    opBusy,
  output logic [N-1:0]    opOverrun
);
  // prev resets to 1 so a trigger held high through reset release is not an edge
  logic prev, accept;

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) prev <= 1'b1;
    else         prev <= ipMasterTrigger;
  end

  assign accept = ipMasterTrigger && !prev;

  for (genvar gi = 0; gi < N; gi++) begin : gCh
    trigger_sequencer_ch #(.W(W), .CW(CW)) uCh (
      .ipClk     (ipClk),
      .ipReset   (ipReset),
      .ipEnable  (ipEnable[gi]),
      .ipDelay   (ipDelay[gi*W +: W]),
      .ipLength  (ipLength[gi*W +: W]),
      .ipPeriod  (ipPeriod[gi*W +: W]),
      .ipCount   (ipCount[gi*CW +: CW]),
      .ipAccept  (accept),
      .opTrigger (opTrigger[gi]),
      .opBusy    (opBusy[gi]),
      .opOverrun (opOverrun[gi])
    );
  end
endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: single pulse, train with overrun, period clamp,
// continuous mode with disable/restart, and asynchronous reset mid-pulse.
module tb_trigger_sequencer;
  localparam int N = 4, W = 32, CW = 8;

  logic            ipClk = 1'b0;
  logic            ipReset;
  logic [N-1:0]    ipEnable;
  logic [N*W-1:0]  ipDelay, ipLength, ipPeriod;
  logic [N*CW-1:0] ipCount;
  logic            ipMasterTrigger;
  logic [N-1:0]    opTrigger, opBusy, opOverrun;

  int nAsserts = 0;
  int nFails   = 0;

  trigger_sequencer #(.N(N), .W(W), .CW(CW)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable),
    .ipDelay(ipDelay), .ipLength(ipLength), .ipPeriod(ipPeriod), .ipCount(ipCount),
    .ipMasterTrigger(ipMasterTrigger),
    .opTrigger(opTrigger), .opBusy(opBusy), .opOverrun(opOverrun)
  );

  always #5 ipClk = ~ipClk;

  task automatic tick();
    @(posedge ipClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setCh(input int i, input int d, input int l, input int p, input int c);
    ipDelay[i*W +: W]   = d;
    ipLength[i*W +: W]  = l;
    ipPeriod[i*W +: W]  = p;
    ipCount[i*CW +: CW] = CW'(c);
  endtask

  initial begin
    bit e;
    ipReset = 1'b1; ipEnable = '0; ipDelay = '0; ipLength = '0; ipPeriod = '0;
    ipCount = '0; ipMasterTrigger = 1'b0;
    tick(); tick();
    chk("reset_trig", 32'(opTrigger), 0);
    chk("reset_busy", 32'(opBusy), 0);
    chk("reset_ovr",  32'(opOverrun), 0);
    ipReset = 1'b0;
    tick(); tick();

    // single pulse on ch0
    setCh(0, 0, 1, 0, 1); ipEnable = 4'b0001;
    ipMasterTrigger = 1'b1; tick();
    chk("single_trig_E", 32'(opTrigger), 32'b0001);
    chk("single_busy_E", 32'(opBusy), 32'b0001);
    ipMasterTrigger = 1'b0; tick();
    chk("single_trig_E1", 32'(opTrigger), 0);
    chk("single_busy_E1", 32'(opBusy), 0);
    tick();

    // ch1 train D=10 L=3 P=8 C=3; second edge at E+5 starts ch2 and overruns ch1
    setCh(1, 10, 3, 8, 3); ipEnable = 4'b0010;
    ipMasterTrigger = 1'b1; tick();
    for (int t = 0; t < 32; t++) begin
      e = 1'b0;
      for (int k = 0; k < 3; k++) if (t >= 10 + 8*k && t < 13 + 8*k) e = 1'b1;
      chk($sformatf("train_trig1_t%0d", t), 32'(opTrigger[1]), 32'(e));
      chk($sformatf("train_busy1_t%0d", t), 32'(opBusy[1]), 32'(t < 29));
      chk($sformatf("train_ovr_t%0d", t), 32'(opOverrun), (t == 5) ? 32'b0010 : 0);
      chk($sformatf("train_trig2_t%0d", t), 32'(opTrigger[2]), 32'(t == 5 || t == 6));
      chk($sformatf("train_busy2_t%0d", t), 32'(opBusy[2]), 32'(t == 5 || t == 6));
      if (t == 0) ipMasterTrigger = 1'b0;
      if (t == 2) setCh(1, 3, 1, 2, 1);  // mid-train write must not disturb ch1
      if (t == 4) begin
        setCh(2, 0, 2, 0, 1); ipEnable = 4'b0110; ipMasterTrigger = 1'b1;
      end
      if (t == 5) ipMasterTrigger = 1'b0;
      tick();
    end

    // period clamp on ch3: L=5 P=2 C=2 -> rises at E and E+6
    setCh(3, 0, 5, 2, 2); ipEnable = 4'b1000;
    ipMasterTrigger = 1'b1; tick();
    for (int t = 0; t < 14; t++) begin
      chk($sformatf("clamp_trig3_t%0d", t), 32'(opTrigger[3]),
          32'((t < 5) || (t >= 6 && t < 11)));
      chk($sformatf("clamp_busy3_t%0d", t), 32'(opBusy[3]), 32'(t < 11));
      if (t == 0) ipMasterTrigger = 1'b0;
      tick();
    end

    // continuous ch0: C=0 D=0 L=2 P=4, >300 pulses across pulse-counter saturation
    setCh(0, 0, 2, 4, 0); ipEnable = 4'b0001;
    ipMasterTrigger = 1'b1; tick();
    for (int t = 0; t < 1300; t++) begin
      chk($sformatf("cont_trig0_t%0d", t), 32'(opTrigger), (t % 4 < 2) ? 32'b0001 : 0);
      chk($sformatf("cont_busy0_t%0d", t), 32'(opBusy), 32'b0001);
      if (t == 0) ipMasterTrigger = 1'b0;
      tick();
    end
    ipEnable = 4'b0000; tick(); tick();
    chk("disable_trig", 32'(opTrigger), 0);
    chk("disable_busy", 32'(opBusy), 0);
    tick();
    chk("disable_hold_busy", 32'(opBusy), 0);

    // restart after disable
    ipEnable = 4'b0001; ipMasterTrigger = 1'b1; tick();
    for (int t = 0; t < 8; t++) begin
      chk($sformatf("restart_trig0_t%0d", t), 32'(opTrigger), (t % 4 < 2) ? 32'b0001 : 0);
      chk($sformatf("restart_busy0_t%0d", t), 32'(opBusy), 32'b0001);
      if (t == 0) ipMasterTrigger = 1'b0;
      tick();
    end
    // now at t=8 of the restarted train: trigger high
    chk("pre_reset_trig", 32'(opTrigger), 32'b0001);

    // asynchronous reset mid-pulse, away from any clock edge
    #1 ipReset = 1'b1;
    #1;
    chk("async_reset_trig", 32'(opTrigger), 0);
    chk("async_reset_busy", 32'(opBusy), 0);
    chk("async_reset_ovr",  32'(opOverrun), 0);
    ipMasterTrigger = 1'b1;
    tick();
    ipReset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("held_trig_busy_t%0d", t), 32'(opBusy), 0);
      chk($sformatf("held_trig_trig_t%0d", t), 32'(opTrigger), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
